// File: rtl/axi_reg_slave.sv
// rtl/axi_reg_slave.sv - AXI burst-capable 32-bit register file slave
// Independent write (AW/W/B) and read (AR/R) FSMs share only the register array.
module axi_reg_slave #(
  parameter int WIDTH_ID    = 4,
  parameter int WIDTH_AD    = 32,
  parameter int ADDR_LENGTH = 6
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [WIDTH_ID-1:0] AWID,
  input  logic [WIDTH_AD-1:0] AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [31:0]         WDATA,
  input  logic [3:0]          WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [WIDTH_ID-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [WIDTH_ID-1:0] ARID,
  input  logic [WIDTH_AD-1:0] ARADDR,
  input  logic [3:0]          ARLEN,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [WIDTH_ID-1:0] RID,
  output logic [31:0]         RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int NREG = 2 ** (ADDR_LENGTH - 2);
  localparam int IDXW = ADDR_LENGTH - 2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t r_wstate, w_wstate_next;
  rstate_t r_rstate, w_rstate_next;

  logic [31:0]         r_regs [0:NREG-1];

  logic [WIDTH_ID-1:0] r_awid;
  logic [WIDTH_AD-1:0] r_awaddr;
  logic [3:0]          r_awlen;
  logic [3:0]          r_wcount;
  logic                r_werr;

  logic [WIDTH_ID-1:0] r_arid;
  logic [WIDTH_AD-1:0] r_araddr;
  logic [3:0]          r_arlen;
  logic [3:0]          r_rcount;
  logic [31:0]         r_rdata;
  logic                r_rerr;

  logic                w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic                w_wr_oor, w_wcount_last, w_wlast_err, w_wburst_end;
  logic [IDXW-1:0]     w_wr_idx;
  logic [WIDTH_AD-1:0] w_rd_addr;
  logic                w_rd_oor;
  logic [IDXW-1:0]     w_rd_idx;

  assign w_aw_hs = AWVALID & AWREADY;
  assign w_w_hs  = WVALID & WREADY;
  assign w_ar_hs = ARVALID & ARREADY;
  assign w_r_hs  = RVALID & RREADY;

  assign w_wr_oor      = (r_awaddr >> ADDR_LENGTH) != '0;
  assign w_wr_idx      = r_awaddr[ADDR_LENGTH-1:2];
  assign w_wcount_last = (r_wcount == r_awlen);
  assign w_wlast_err   = (WLAST != w_wcount_last);
  assign w_wburst_end  = w_w_hs & (WLAST | w_wcount_last);

  // Read data is registered from the address of the beat about to be presented,
  // so it stays stable while RREADY is low even if the same register is written.
  assign w_rd_addr = (r_rstate == R_IDLE) ? ARADDR : r_araddr + WIDTH_AD'(4);
  assign w_rd_oor  = (w_rd_addr >> ADDR_LENGTH) != '0;
  assign w_rd_idx  = w_rd_addr[ADDR_LENGTH-1:2];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
      r_rstate <= w_rstate_next;
    end
  end

  always_comb begin
    w_wstate_next = r_wstate;
    AWREADY       = 1'b0;
    WREADY        = 1'b0;
    BVALID        = 1'b0;
    BID           = '0;
    BRESP         = 2'b00;
    case (r_wstate)
      W_IDLE: begin
        AWREADY = ~ARESET;
        if (w_aw_hs) w_wstate_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (w_wburst_end) w_wstate_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        BID    = r_awid;
        BRESP  = r_werr ? 2'b10 : 2'b00;
        if (BREADY) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rstate_next = r_rstate;
    ARREADY       = 1'b0;
    RVALID        = 1'b0;
    RID           = '0;
    RDATA         = '0;
    RRESP         = 2'b00;
    RLAST         = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        ARREADY = ~ARESET;
        if (w_ar_hs) w_rstate_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        RID    = r_arid;
        RDATA  = r_rdata;
        RRESP  = r_rerr ? 2'b10 : 2'b00;
        RLAST  = (r_rcount == r_arlen);
        if (w_r_hs && RLAST) w_rstate_next = R_IDLE;
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awid   <= '0;
      r_awaddr <= '0;
      r_awlen  <= '0;
      r_wcount <= '0;
      r_werr   <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_aw_hs) begin
        r_awid   <= AWID;
        r_awaddr <= AWADDR;
        r_awlen  <= AWLEN;
        r_wcount <= '0;
        r_werr   <= 1'b0;
      end
      if (w_w_hs) begin
        if (!w_wr_oor) begin
          for (int b = 0; b < 4; b++) begin
            if (WSTRB[b]) r_regs[w_wr_idx][8*b +: 8] <= WDATA[8*b +: 8];
          end
        end
        r_awaddr <= r_awaddr + WIDTH_AD'(4);
        r_wcount <= r_wcount + 4'd1;
        if (w_wr_oor || w_wlast_err) r_werr <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arid   <= '0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_rcount <= '0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_arid   <= ARID;
        r_araddr <= ARADDR;
        r_arlen  <= ARLEN;
        r_rcount <= '0;
      end
      if (w_r_hs) begin
        r_araddr <= r_araddr + WIDTH_AD'(4);
        r_rcount <= r_rcount + 4'd1;
      end
      if (w_ar_hs || w_r_hs) begin
        r_rdata <= w_rd_oor ? 32'd0 : r_regs[w_rd_idx];
        r_rerr  <= w_rd_oor;
      end
    end
  end

endmodule

// File: tb/tb_axi_reg_slave.sv
// tb/tb_axi_reg_slave.sv - scoreboard bench for axi_reg_slave
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_reg_slave;

  localparam int LIM = 64;

  typedef struct {
    logic [3:0] id;
    logic [1:0] r;
  } bexp_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } rexp_t;

  logic        ACLK, ARESET;
  logic [3:0]  AWID, AWLEN, WSTRB, ARID, ARLEN;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic        AWVALID, WLAST, WVALID, BREADY, ARVALID, RREADY;
  logic        AWREADY, WREADY, BVALID, ARREADY, RLAST, RVALID;
  logic [3:0]  BID, RID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;

  logic [31:0] m_regs [16];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  bexp_t       wq [$];
  rexp_t       rq [$];
  int          n_vec, n_err;

  axi_reg_slave #(.WIDTH_ID(4), .WIDTH_AD(32), .ADDR_LENGTH(6)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int ch);
    case (ch)
      0:       return AWREADY;
      1:       return WREADY;
      2:       return ARREADY;
      3:       return BVALID;
      default: return RVALID;
    endcase
  endfunction

  task automatic wait_hi(input int ch, input string tag);
    int t;
    t = 0;
    while (!sig(ch) && t < LIM) begin
      @(negedge ACLK);
      t++;
    end
    chk(tag, 32'(t >= LIM), 32'd0);
  endtask

  task automatic hs(input int ch, input string tag);
    wait_hi(ch, tag);
    @(negedge ACLK);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_awready"}, 32'(AWREADY), 0);
    chk({tag, "_arready"}, 32'(ARREADY), 0);
    chk({tag, "_wready"},  32'(WREADY), 0);
    chk({tag, "_bvalid"},  32'(BVALID), 0);
    chk({tag, "_rvalid"},  32'(RVALID), 0);
    chk({tag, "_rlast"},   32'(RLAST), 0);
    chk({tag, "_bid"},     32'(BID), 0);
    chk({tag, "_rid"},     32'(RID), 0);
    chk({tag, "_rdata"},   RDATA, 0);
    chk({tag, "_bresp"},   32'(BRESP), 0);
    chk({tag, "_rresp"},   32'(RRESP), 0);
  endtask

  // last_at: beat index carrying WLAST; a value above len means WLAST never rises
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                           input int last_at, input int bdly);
    logic [31:0] a;
    logic        err;
    int          nb;
    bexp_t       e, g;
    nb  = (last_at < int'(len)) ? last_at + 1 : int'(len) + 1;
    err = (last_at != int'(len));
    a   = addr;
    for (int i = 0; i < nb; i++) begin
      if (a[31:6] != 0) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (ws[i][b]) m_regs[a[5:2]][8*b +: 8] = wd[i][8*b +: 8];
      a = a + 32'd4;
    end
    e.id = id;
    e.r  = err ? 2'b10 : 2'b00;
    wq.push_back(e);
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    hs(0, "aw_timeout");
    AWVALID = 1'b0;
    for (int i = 0; i < nb; i++) begin
      WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == last_at); WVALID = 1'b1;
      hs(1, "w_timeout");
    end
    WVALID = 1'b0; WLAST = 1'b0;
    wait_hi(3, "b_timeout");
    g = wq.pop_front();
    for (int k = 0; k <= bdly; k++) begin
      chk("bvalid", 32'(BVALID), 1);
      chk("bid", 32'(BID), 32'(g.id));
      chk("bresp", 32'(BRESP), 32'(g.r));
      if (k < bdly) @(negedge ACLK);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("bvalid_drop", 32'(BVALID), 0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input int rdly);
    logic [31:0] a;
    rexp_t       e, g;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id;
      e.l  = (i == int'(len));
      if (a[31:6] != 0) begin e.d = 32'd0; e.r = 2'b10; end
      else begin e.d = m_regs[a[5:2]]; e.r = 2'b00; end
      rq.push_back(e);
      a = a + 32'd4;
    end
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    hs(2, "ar_timeout");
    ARVALID = 1'b0;
    while (rq.size() > 0) begin
      wait_hi(4, "r_timeout");
      g = rq.pop_front();
      for (int k = 0; k <= rdly; k++) begin
        chk("rvalid", 32'(RVALID), 1);
        chk("rid", 32'(RID), 32'(g.id));
        chk("rdata", RDATA, g.d);
        chk("rresp", 32'(RRESP), 32'(g.r));
        chk("rlast", 32'(RLAST), 32'(g.l));
        if (k < rdly) @(negedge ACLK);
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
    chk("rvalid_drop", 32'(RVALID), 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    ARESET = 1'b1;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWVALID = 0;
    WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    repeat (3) @(negedge ACLK);
    chk_zero("reset");
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("awready_after_reset", 32'(AWREADY), 1);
    chk("arready_after_reset", 32'(ARREADY), 1);

    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(32'h10, 4'd0, 4'd3, 0, 0);
    axi_read(32'h10, 4'd0, 4'd5, 0);

    wd[0] = 32'hAAAA5555; ws[0] = 4'h3;
    axi_write(32'h10, 4'd0, 4'd4, 0, 0);
    axi_read(32'h10, 4'd0, 4'd6, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    axi_write(32'h00, 4'd3, 4'd1, 3, 0);
    axi_read(32'h00, 4'd3, 4'd2, 0);

    axi_read(32'h40, 4'd0, 4'd7, 0);
    wd[0] = 32'h0F0F0F0F; wd[1] = 32'h99999999; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(32'h3C, 4'd1, 4'd8, 1, 0);
    axi_read(32'h00, 4'd15, 4'd9, 0);

    wd[0] = 32'h12345678; ws[0] = 4'hF;
    axi_write(32'h24, 4'd0, 4'd7, 0, 5);
    axi_read(32'h24, 4'd0, 4'd9, 5);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE0000 + 32'(i); ws[i] = 4'hF; end
    axi_write(32'h20, 4'd3, 4'hA, 1, 0);
    axi_write(32'h30, 4'd1, 4'hB, 5, 0);
    wd[0] = 32'h55AA55AA; wd[1] = 32'hFEEDF00D; ws[0] = 4'hF; ws[1] = 4'hC;
    axi_write(32'hFFFF_FFFC, 4'd1, 4'hC, 1, 0);
    axi_read(32'h00, 4'd15, 4'hD, 0);

    AWID = 4'd1; AWADDR = 32'h0; AWLEN = 4'd3; AWVALID = 1'b1;
    hs(0, "aw_timeout");
    AWVALID = 1'b0;
    WDATA = 32'h11111111; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    hs(1, "w_timeout");
    WDATA = 32'h22222222;
    ARESET = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    chk_zero("reset_mid_burst");
    ARESET = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    @(negedge ACLK);
    chk("awready_after_mid_reset", 32'(AWREADY), 1);
    axi_read(32'h00, 4'd15, 4'hE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
